// File: rtl/encoder_pkg.sv
// Shared types and fixed-point helpers for the sequential dense-layer encoder.
// Saturation works on a wide signed container, so any lane width up to MAX_W can use it.
package encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam int MAX_W     = 128;
    localparam int MAX_ACC_W = 2 * MAX_W + 32;

    typedef logic signed [MAX_ACC_W-1:0] wide_t;

    typedef struct packed {
        logic signed [MAX_W-1:0] word;
        logic                    sat;
    } sat_res_t;

    // Q16.16 limits for the default 32-bit word.
    localparam logic signed [31:0] Q32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] Q32_MIN = 32'sh8000_0000;

    function automatic int acc_width(input int bitsize, input int frac, input int n_input);
        return 2 * bitsize - frac + $clog2(n_input) + 1;
    endfunction

    function automatic wide_t q_max(input int bitsize);
        return (wide_t'(1) <<< (bitsize - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t q_min(input int bitsize);
        return -(wide_t'(1) <<< (bitsize - 1));
    endfunction

    function automatic sat_res_t sat_to_word(input wide_t value, input int bitsize);
        sat_res_t r;
        if (value > q_max(bitsize)) begin
            r.word = MAX_W'(q_max(bitsize));
            r.sat  = 1'b1;
        end else if (value < q_min(bitsize)) begin
            r.word = MAX_W'(q_min(bitsize));
            r.sat  = 1'b1;
        end else begin
            r.word = MAX_W'(value);
            r.sat  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/encoder_fixed_point_seq_mac_lane.sv
// One output channel: a wide accumulator fed with floor-shifted products, then a
// combinational bias/saturate/ReLU finish that the top level registers.
module fixed_point_mac_lane
    import encoder_pkg::*;
#(
    parameter int BITSIZE = 32,
    parameter int FRAC    = 16,
    parameter int N_input = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [BITSIZE-1:0] a,
    input  logic [BITSIZE-1:0] b,
    input  logic [BITSIZE-1:0] bias,
    input  logic               relu,
    output logic [BITSIZE-1:0] res_word,
    output logic               res_sat
);

    localparam int ACC_W  = acc_width(BITSIZE, FRAC, N_input);
    localparam int PROD_W = 2 * BITSIZE - FRAC;

    logic signed [2*BITSIZE-1:0] full;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     y;
    sat_res_t                    fin;

    assign full = $signed({{BITSIZE{a[BITSIZE-1]}}, a}) * $signed({{BITSIZE{b[BITSIZE-1]}}, b});
    // Arithmetic shift floors toward minus infinity, matching the reference model.
    assign prod = PROD_W'(full >>> FRAC);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    assign y   = acc_q + {{(ACC_W-BITSIZE){bias[BITSIZE-1]}}, bias};
    assign fin = sat_to_word({{(MAX_ACC_W-ACC_W){y[ACC_W-1]}}, y}, BITSIZE);

    // ReLU acts on the saturated word; the flag still reports the clamp.
    assign res_word = (relu && fin.word[BITSIZE-1]) ? '0 : BITSIZE'(fin.word);
    assign res_sat  = fin.sat;

endmodule

// File: rtl/encoder_fixed_point_seq.sv
// Time-multiplexed dense-layer encoder: out[j] = act(sum_i x[i]*w[j][i] + b[j]),
// one input per clock across M_output parallel MAC lanes, valid/ready on both sides.
module encoder_fixed_point_seq
    import encoder_pkg::*;
#(
    parameter int N_input  = 9,
    parameter int M_output = 4,
    parameter int BITSIZE  = 32,
    parameter int FRAC     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            act_sel,
    input  logic [N_input*BITSIZE-1:0]          x,
    input  logic [N_input*M_output*BITSIZE-1:0] w,
    input  logic [M_output*BITSIZE-1:0]         b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [M_output*BITSIZE-1:0]     out,
    output logic [M_output-1:0]             out_sat
);

    localparam int IDX_W = (N_input > 1) ? $clog2(N_input) : 1;

    state_t                              state;
    logic [IDX_W-1:0]                    idx;
    logic [N_input*BITSIZE-1:0]          x_q;
    logic [N_input*M_output*BITSIZE-1:0] w_q;
    logic [M_output*BITSIZE-1:0]         b_q;
    logic                                act_q;
    logic                                accept;
    logic                                last;
    logic [BITSIZE-1:0]                  x_cur;
    logic [M_output*BITSIZE-1:0]         res_word;
    logic [M_output-1:0]                 res_sat;

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign last      = (idx == IDX_W'(N_input - 1));
    assign out_valid = (state == ST_OUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            out     <= '0;
            out_sat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_MAC;
                        idx   <= '0;
                    end
                end
                ST_MAC: begin
                    idx <= idx + IDX_W'(1);
                    if (last) begin
                        state <= ST_BIAS;
                    end
                end
                ST_BIAS: begin
                    out     <= res_word;
                    out_sat <= res_sat;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: operand latches are pure data qualified by accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_q   <= x;
            w_q   <= w;
            b_q   <= b;
            act_q <= act_sel;
        end
    end

    assign x_cur = x_q[int'(idx)*BITSIZE +: BITSIZE];

    for (genvar j = 0; j < M_output; j++) begin : g_lane
        fixed_point_mac_lane #(
            .BITSIZE(BITSIZE),
            .FRAC   (FRAC),
            .N_input(N_input)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear   (accept),
            .enable  (state == ST_MAC),
            .a       (x_cur),
            .b       (w_q[(j*N_input + int'(idx))*BITSIZE +: BITSIZE]),
            .bias    (b_q[j*BITSIZE +: BITSIZE]),
            .relu    (act_q),
            .res_word(res_word[j*BITSIZE +: BITSIZE]),
            .res_sat (res_sat[j])
        );
    end

endmodule

// File: tb/tb_encoder_fixed_point_seq.sv
// Directed bench for encoder_fixed_point_seq at defaults (9 inputs, 4 lanes, Q16.16).
module tb_encoder_fixed_point_seq;

    localparam int N = 9;
    localparam int M = 4;
    localparam int B = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           act_sel;
    logic [N*B-1:0]   x;
    logic [N*M*B-1:0] w;
    logic [M*B-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [M*B-1:0] out;
    logic [M-1:0]   out_sat;

    int tests_run    = 0;
    int tests_failed = 0;
    int latency;
    bit timed_out;

    always #5 clk = ~clk;

    encoder_fixed_point_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .act_sel  (act_sel),
        .x        (x),
        .w        (w),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .out_sat  (out_sat)
    );

    task automatic fill(input logic [31:0] xv, input logic [31:0] wv, input logic [31:0] bv);
        for (int i = 0; i < N; i++) x[i*B +: B] = xv;
        for (int k = 0; k < N*M; k++) w[k*B +: B] = wv;
        for (int j = 0; j < M; j++) b[j*B +: B] = bv;
    endtask

    // Called just after a rising edge with the DUT idle; returns once out_valid is seen.
    task automatic send(input logic act);
        act_sel  = act;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        latency   = 0;
        timed_out = 1'b0;
        while (!out_valid && !timed_out) begin
            @(posedge clk);
            #1 latency++;
            if (latency > 40) timed_out = 1'b1;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        act_sel   = 1'b0;
        fill(32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out !== '0 || out_sat !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: out=%h sat=%b vld=%b rdy=%b, expected all zero", out, out_sat, out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_linear();
        fill(32'h0001_0000, 32'h0000_8000, 32'h0000_4000);
        send(1'b0);
        tests_run++;
        if (timed_out || latency != 10) begin
            tests_failed++;
            $display("FAIL linear_latency: got %0d cycles (timeout=%b), expected 10", latency, timed_out);
        end
        for (int j = 0; j < M; j++) begin
            tests_run++;
            if (out[j*B +: B] !== 32'h0004_C000 || out_sat[j] !== 1'b0) begin
                tests_failed++;
                $display("FAIL linear_out[%0d]: got %h sat %b, expected 0004c000 sat 0", j, out[j*B +: B], out_sat[j]);
            end
        end
        handshake();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out[31:0] !== 32'h0004_C000) begin
            tests_failed++;
            $display("FAIL linear_after_hs: vld=%b rdy=%b out0=%h, expected 0 1 0004c000", out_valid, in_ready, out[31:0]);
        end
    endtask

    task automatic test_negative_relu();
        fill(32'h0001_0000, 32'hFFFF_8000, 32'h0000_4000);
        send(1'b0);
        for (int j = 0; j < M; j++) begin
            tests_run++;
            if (timed_out || out[j*B +: B] !== 32'hFFFB_C000 || out_sat[j] !== 1'b0) begin
                tests_failed++;
                $display("FAIL neg_linear_out[%0d]: got %h sat %b, expected fffbc000 sat 0", j, out[j*B +: B], out_sat[j]);
            end
        end
        handshake();
        send(1'b1);
        for (int j = 0; j < M; j++) begin
            tests_run++;
            if (timed_out || out[j*B +: B] !== 32'h0 || out_sat[j] !== 1'b0) begin
                tests_failed++;
                $display("FAIL neg_relu_out[%0d]: got %h sat %b, expected 00000000 sat 0", j, out[j*B +: B], out_sat[j]);
            end
        end
        handshake();
    endtask

    task automatic test_saturation();
        fill(32'h7FFF_0000, 32'h7FFF_0000, 32'h0);
        send(1'b0);
        for (int j = 0; j < M; j++) begin
            tests_run++;
            if (timed_out || out[j*B +: B] !== 32'h7FFF_FFFF || out_sat[j] !== 1'b1) begin
                tests_failed++;
                $display("FAIL sat_pos_out[%0d]: got %h sat %b, expected 7fffffff sat 1", j, out[j*B +: B], out_sat[j]);
            end
        end
        handshake();
        fill(32'h7FFF_0000, 32'h8001_0000, 32'h0);
        send(1'b0);
        for (int j = 0; j < M; j++) begin
            tests_run++;
            if (timed_out || out[j*B +: B] !== 32'h8000_0000 || out_sat[j] !== 1'b1) begin
                tests_failed++;
                $display("FAIL sat_neg_out[%0d]: got %h sat %b, expected 80000000 sat 1", j, out[j*B +: B], out_sat[j]);
            end
        end
        handshake();
        send(1'b1);
        tests_run++;
        if (timed_out || out[31:0] !== 32'h0 || out_sat[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_neg_relu: got %h sat %b, expected 00000000 sat 1", out[31:0], out_sat[0]);
        end
        handshake();
    endtask

    task automatic test_index_layout();
        logic [31:0] expv [M] = '{32'h0009_0000, 32'h0012_0000, 32'h001B_0000, 32'h0024_0000};
        fill(32'h0001_0000, 32'h0, 32'h0);
        for (int j = 0; j < M; j++)
            for (int i = 0; i < N; i++)
                w[(j*N + i)*B +: B] = (j + 1) << 16;
        send(1'b0);
        for (int j = 0; j < M; j++) begin
            tests_run++;
            if (timed_out || out[j*B +: B] !== expv[j] || out_sat[j] !== 1'b0) begin
                tests_failed++;
                $display("FAIL layout_out[%0d]: got %h sat %b, expected %h sat 0", j, out[j*B +: B], out_sat[j], expv[j]);
            end
        end
        handshake();
    endtask

    task automatic test_floor();
        fill(32'h0, 32'h0000_0001, 32'h0);
        x[31:0] = 32'hFFFF_FFFF;
        send(1'b0);
        for (int j = 0; j < M; j++) begin
            tests_run++;
            if (timed_out || out[j*B +: B] !== 32'hFFFF_FFFF || out_sat[j] !== 1'b0) begin
                tests_failed++;
                $display("FAIL floor_neg_out[%0d]: got %h, expected ffffffff", j, out[j*B +: B]);
            end
        end
        handshake();
        x[31:0] = 32'h0000_0001;
        send(1'b0);
        tests_run++;
        if (timed_out || out !== '0 || out_sat !== '0) begin
            tests_failed++;
            $display("FAIL floor_pos_out: got %h sat %b, expected all zero", out, out_sat);
        end
        handshake();
    endtask

    task automatic test_back_to_back_hold();
        logic [M*B-1:0] held;
        fill(32'h0001_0000, 32'h0000_8000, 32'h0000_4000);
        send(1'b0);
        held = out;
        tests_run++;
        if (timed_out || held[31:0] !== 32'h0004_C000) begin
            tests_failed++;
            $display("FAIL hold_first: got %h, expected 0004c000", held[31:0]);
        end
        fill(32'h0002_0000, 32'h0001_0000, 32'h0);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: out0=%h vld=%b rdy=%b, expected 0004c000 1 0", c, out[31:0], out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        handshake();
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== held) begin
            tests_failed++;
            $display("FAIL hold_no_queue: vld=%b rdy=%b out0=%h, expected 0 1 0004c000", out_valid, in_ready, out[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        fill(32'h0001_0000, 32'h0000_8000, 32'h0000_4000);
        act_sel  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out !== '0 || out_sat !== '0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_abort: vld=%b out=%h sat=%b rdy=%b, expected 0 0 0 0", out_valid, out, out_sat, in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_release: rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
        end
        send(1'b0);
        tests_run++;
        if (timed_out || latency != 10 || out[M*B-1 -: B] !== 32'h0004_C000 || out_sat !== '0) begin
            tests_failed++;
            $display("FAIL midrst_next: lat=%0d out3=%h sat=%b, expected 10 0004c000 0", latency, out[M*B-1 -: B], out_sat);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_linear();
        test_negative_relu();
        test_saturation();
        test_index_layout();
        test_floor();
        test_back_to_back_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
